// File: rtl/vga_capture.sv
// vga_capture - recovers pixel coordinates and colour from a VGA-style
// hsync/vsync/rgb stream sampled on a pixel strobe, and locks onto the
// incoming timing once two consecutive frames look consistent.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   p_tick            one-clk pixel strobe; inputs are sampled only here
//   hsync, vsync      active-low sync inputs
//   rgb[11:0]         pixel colour
//   pix_x, pix_y      recovered column/row of the captured pixel
//   pix_rgb           captured colour
//   pix_valid         one-clk pulse: pix_x/pix_y/pix_rgb hold an active pixel
//   frame_start       one-clk pulse on a clean vsync rise while locked
//   locked            high while in the LOCKED state
//   timing_err        one-clk pulse on a line or frame length violation
//   frame_sum[15:0]   (VGA_CAPTURE_CRC_EN only) mod-2^16 sum of the
//                     previous locked frame's captured pixel colours
//
// Optional feature macro: VGA_CAPTURE_CRC_EN
module vga_capture #(
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
`ifdef VGA_CAPTURE_CRC_EN
  output logic [15:0] frame_sum,
`endif
  output logic        timing_err
);

  localparam logic [9:0] H_LO   = 10'(H_BP);
  localparam logic [9:0] H_HI   = 10'(H_BP + H_ACT - 1);
  localparam logic [9:0] V_LO   = 10'(V_BP);
  localparam logic [9:0] V_HI   = 10'(V_BP + V_ACT - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FULL = 10'(V_TOTAL);
  localparam logic [9:0] C_MAX  = '1;

  typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

  state_t     state, state_nx;
  logic       prev_hs, prev_vs;
  logic [9:0] hcnt, vcnt, hcnt_nx, vcnt_nx;
  logic       h_rise, v_rise, line_err, frame_err, err;
  logic       active, valid_nx, fs_nx;

  assign locked = (state == LOCKED);

  always_comb begin
    h_rise = ~prev_hs & hsync;
    v_rise = ~prev_vs & vsync;

    if (h_rise)               hcnt_nx = '0;
    else if (hcnt == C_MAX)   hcnt_nx = hcnt;
    else                      hcnt_nx = hcnt + 10'd1;

    // vsync rise wins over a coincident hsync rise
    if (v_rise)                        vcnt_nx = '0;
    else if (h_rise && vcnt != C_MAX)  vcnt_nx = vcnt + 10'd1;
    else                               vcnt_nx = vcnt;

    // Length checks look at the count reached just before the reload.
    line_err  = (state != SEARCH) & h_rise & (hcnt != H_LAST);
    frame_err = (state != SEARCH) & v_rise & (vcnt != V_FULL);
    err       = p_tick & (line_err | frame_err);

    // The current sample's coordinates are the post-update counts.
    active   = (hcnt_nx >= H_LO) && (hcnt_nx <= H_HI) &&
               (vcnt_nx >= V_LO) && (vcnt_nx <= V_HI);
    valid_nx = p_tick & (state == LOCKED) & active;
    fs_nx    = p_tick & (state == LOCKED) & v_rise & ~frame_err & ~line_err;

    state_nx = state;
    if (p_tick) begin
      unique case (state)
        SEARCH: if (v_rise) state_nx = TRAIN;
        TRAIN: begin
          if (err)         state_nx = SEARCH;
          else if (v_rise) state_nx = LOCKED;
        end
        LOCKED: if (err)   state_nx = SEARCH;
        default:           state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      prev_hs     <= 1'b1;
      prev_vs     <= 1'b1;
      hcnt        <= '0;
      vcnt        <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      state       <= state_nx;
      pix_valid   <= valid_nx;
      frame_start <= fs_nx;
      timing_err  <= err;
      if (p_tick) begin
        prev_hs <= hsync;
        prev_vs <= vsync;
        hcnt    <= hcnt_nx;
        vcnt    <= vcnt_nx;
      end
      if (valid_nx) begin
        pix_x   <= hcnt_nx - H_LO;
        pix_y   <= vcnt_nx - V_LO;
        pix_rgb <= rgb;
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] acc;

  // Accumulator only holds data while locked, so the first locked frame
  // starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      frame_sum <= '0;
    end else if (fs_nx) begin
      frame_sum <= acc;
      acc       <= '0;
    end else if (state != LOCKED) begin
      acc <= '0;
    end else if (valid_nx) begin
      acc <= acc + {4'h0, rgb};
    end
  end
`endif

endmodule
